mem_request_queue: RTL
======================

Name: mem_request_queue

Overview:
Synthesizable 16-entry request queue that sits directly upstream of the DRAM command scheduler.
- Accepts time-stamped CPU requests (time, core, operation, address) from the trace front-end.
- Holds each request until the free-running CPU time reaches its arrival time.
- Presents the head entry, with the DDR5 address fields already decoded, to the scheduler over a valid/ready handshake.

Parameters:
DEPTH, 16, queue entries (power of two, at least 2)
TIME_W, 64, width of arrival timestamps and the CPU time counter
ADDR_W, 36, physical address width
MAX_CORE, 12, first illegal core ID

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request offered
in_ready  out  1  queue can accept
in_time  in  TIME_W  arrival time of request
in_core  in  4  core ID
in_op  in  2  0=data read, 1=data write, 2=ifetch, 3=illegal
in_addr  in  ADDR_W  physical address
out_valid  out  1  head entry eligible
out_ready  in  1  scheduler takes head
out_op  out  2  head operation
out_core  out  4  head core
out_addr  out  ADDR_W  head raw address
out_channel  out  1  addr[6]
out_bg  out  3  addr[9:7]
out_bank  out  2  addr[11:10]
out_row  out  16  addr[33:18]
out_col  out  10  {addr[17:12], addr[5:2]}
cpu_time  out  TIME_W  free-running time counter
occupancy  out  5  entries held (0..DEPTH)
full  out  1  occupancy==DEPTH
empty  out  1  occupancy==0
err_illegal  out  1  sticky: illegal request dropped
err_order  out  1  sticky: non-monotonic arrival time accepted
drop_count  out  8  saturating count of dropped requests

Behaviour:
Clock and reset:
- One clock. Reset is asynchronous and active-low.
- Reset values: cpu_time=0, occupancy=0, empty=1, full=0, out_valid=0, err_illegal=0, err_order=0, drop_count=0, pointers=0, last_time=0.
- Assertion of reset mid-operation discards all entries immediately.

CPU time:
- cpu_time increments by 1 every cycle after reset and wraps at 2^TIME_W.

Push:
- in_ready = !full, combinational. There is no bypass at full, including when a pop occurs in the same cycle.
- A handshake (in_valid && in_ready) is legal when in_op!=3 and in_core<MAX_CORE.
- Legal handshake: write {time,core,op,addr} at the write pointer and update last_time.
- Illegal handshake: consume and drop, set err_illegal, increment drop_count (saturates at 255), no write.
- A legal request with in_time < last_time (after the first push) is still stored, and err_order is set.

Eligibility and pop:
- out_valid = !empty && (head.time <= cpu_time). Unsigned compare.
- Output fields are driven from head storage whenever !empty. They are don't-care when empty.
- A pop happens on out_valid && out_ready.
- FIFO order is strict: a later entry with an earlier timestamp never overtakes the head.

Latency:
- A request pushed into an empty queue raises out_valid no earlier than the next cycle, and not before cpu_time >= in_time.

Pointers and flags:
- log2(DEPTH) bits each, plus a wrap bit. Wrap-around is seamless.
- Simultaneous push and pop on a non-full, non-empty queue leaves occupancy unchanged.
- full and empty are registered, derived from next-state occupancy.

Timestamps:
- No timing check is done on decoded fields; timing is owned by the scheduler.

Decomposition:
- Shared package additions (alongside timing_parameters):
  - op_t enum: READ=0, WRITE=1, IFETCH=2.
  - Address bit-position constants for channel, bank group, bank, row and column.
  - dram_addr_t packed struct {channel, bg, bank, row, col}.
  - Function decode_addr(addr) returning dram_addr_t.
- One natural sub-module: req_fifo, a generic parameterized synchronous FIFO with occupancy, full and empty.
  - mem_request_queue wraps req_fifo and adds the time counter, eligibility gate, legality check, error flags and decode.

Test Plan:
- Reset, then push {time=5, core=1, op=0, addr=36'h0_0004_0CC4} at cpu_time=1 -> out_valid stays low until cpu_time=5, then out_channel=1, out_bg=1, out_bank=3, out_row=16'h0001, out_col=10'h001, out_op=0.
- Push 16 legal requests with time=0, out_ready=0 -> full=1, in_ready=0, occupancy=16. A 17th offer is not accepted. Set out_ready=1 -> entries pop in order, one per cycle, and empty=1 after the 16th pop.
- Push op=3, then core=12 -> both consumed, nothing stored, err_illegal=1, drop_count=2, occupancy=0.
- Push times 100 then 50 -> err_order=1. Head (time 100) blocks the time-50 entry until cpu_time>=100, then both pop in order.
- Steady push+pop each cycle at occupancy 8 for 40 cycles -> occupancy stays 8 and pointers wrap correctly, with data integrity checked by a scoreboard.
- Assert rst_n low mid-stream with occupancy 5 -> immediately occupancy=0, out_valid=0, cpu_time=0, and error flags cleared.

Source files
------------

// File: rtl/mem_request_queue_pkg.sv
// Shared types and constants for the DRAM request queue: operation codes,
// DDR5 address-field positions and the address decode helper.
package mem_request_queue_pkg;

  // Nominal DDR5-4800 timing in clock cycles, consumed by the scheduler
  localparam int unsigned T_RCD_CK = 32'd39;
  localparam int unsigned T_RP_CK  = 32'd39;
  localparam int unsigned T_CL_CK  = 32'd40;
  localparam int unsigned T_RAS_CK = 32'd77;

  typedef enum logic [1:0] {
    READ   = 2'd0,
    WRITE  = 2'd1,
    IFETCH = 2'd2
  } op_t;

  localparam int unsigned CH_BIT     = 32'd6;
  localparam int unsigned BG_LSB     = 32'd7;
  localparam int unsigned BG_W       = 32'd3;
  localparam int unsigned BANK_LSB   = 32'd10;
  localparam int unsigned BANK_W     = 32'd2;
  localparam int unsigned ROW_LSB    = 32'd18;
  localparam int unsigned ROW_W      = 32'd16;
  localparam int unsigned COL_HI_LSB = 32'd12;
  localparam int unsigned COL_HI_W   = 32'd6;
  localparam int unsigned COL_LO_LSB = 32'd2;
  localparam int unsigned COL_LO_W   = 32'd4;
  localparam int unsigned DECODE_W   = 32'd34;

  typedef struct packed {
    logic                channel;
    logic [BG_W-1:0]     bg;
    logic [BANK_W-1:0]   bank;
    logic [ROW_W-1:0]    row;
    logic [COL_HI_W+COL_LO_W-1:0] col;
  } dram_addr_t;

  // Address bits [1:0] are below burst granularity and are not decoded
  function automatic dram_addr_t decode_addr(input logic [DECODE_W-1:0] addr);
    dram_addr_t d;
    d.channel = addr[CH_BIT];
    d.bg      = addr[BG_LSB +: BG_W];
    d.bank    = addr[BANK_LSB +: BANK_W];
    d.row     = addr[ROW_LSB +: ROW_W];
    d.col     = {addr[COL_HI_LSB +: COL_HI_W], addr[COL_LO_LSB +: COL_LO_W]};
    return d;
  endfunction

endpackage

// File: rtl/mem_request_queue_req_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; occupancy, full and
// empty are registered from the next-state pointer difference.
module req_fifo #(
  parameter  int unsigned WIDTH = 32'd8,
  parameter  int unsigned DEPTH = 32'd16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 32'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0]   PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [PTR_W:0]   wr_ptr_next_s;
  logic [PTR_W:0]   rd_ptr_next_s;
  logic [CNT_W-1:0] occ_next_s;
  logic [CNT_W-1:0] occ_r;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A push is never accepted at full, even if a pop happens in the same cycle
  assign do_push_s = push && !full_r;
  assign do_pop_s  = pop && !empty_r;

  // Next-state pointers and the occupancy they imply
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    if (do_push_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (do_pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    occ_next_s = wr_ptr_next_s - rd_ptr_next_s;
  end

  // Pointer and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
      occ_r    <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      occ_r    <= occ_next_s;
      full_r   <= (occ_next_s == CNT_DEPTH);
      empty_r  <= (occ_next_s == CNT_ZERO);
    end
  end

  // Entry storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= wr_data;
    end
  end

  assign rd_data   = mem_r[rd_ptr_r[PTR_W-1:0]];
  assign occupancy = occ_r;
  assign full      = full_r;
  assign empty     = empty_r;

endmodule

// File: rtl/mem_request_queue.sv
// Time-gated request queue in front of the DRAM scheduler: holds requests
// until CPU time reaches their arrival stamp and presents decoded DDR5 fields.
module mem_request_queue
  import mem_request_queue_pkg::*;
#(
  parameter  int unsigned DEPTH    = 32'd16,
  parameter  int unsigned TIME_W   = 32'd64,
  parameter  int unsigned ADDR_W   = 32'd36,
  parameter  int unsigned MAX_CORE = 32'd12,
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 32'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TIME_W-1:0] in_time,
  input  logic [3:0]        in_core,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_op,
  output logic [3:0]        out_core,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_channel,
  output logic [2:0]        out_bg,
  output logic [1:0]        out_bank,
  output logic [15:0]       out_row,
  output logic [9:0]        out_col,
  output logic [TIME_W-1:0] cpu_time,
  output logic [CNT_W-1:0]  occupancy,
  output logic              full,
  output logic              empty,
  output logic              err_illegal,
  output logic              err_order,
  output logic [7:0]        drop_count
);

  typedef struct packed {
    logic [TIME_W-1:0] arr_time;
    logic [3:0]        core;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  localparam int unsigned     ENTRY_W  = $bits(entry_t);
  localparam logic [TIME_W-1:0] TIME_ONE = {{(TIME_W-1){1'b0}}, 1'b1};

  entry_t            wr_entry_s;
  entry_t            head_s;
  dram_addr_t        head_dec_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_occ_s;
  logic              op_ok_s;
  logic              core_ok_s;
  logic              accept_s;
  logic              push_s;
  logic              drop_s;
  logic              eligible_s;
  logic              pop_s;
  logic [TIME_W-1:0] cpu_time_r;
  logic [TIME_W-1:0] last_time_r;
  logic              err_illegal_r;
  logic              err_order_r;
  logic [7:0]        drop_count_r;

  // Request legality: opcode must be a known operation and core ID in range
  always_comb begin
    op_ok_s = 1'b0;
    case (op_t'(in_op))
      READ, WRITE, IFETCH: op_ok_s = 1'b1;
      default:             op_ok_s = 1'b0;
    endcase
    core_ok_s = (32'(in_core) < MAX_CORE);
  end

  assign in_ready   = !fifo_full_s;
  assign accept_s   = in_valid && in_ready;
  assign push_s     = accept_s && op_ok_s && core_ok_s;
  assign drop_s     = accept_s && !(op_ok_s && core_ok_s);
  assign wr_entry_s = '{arr_time: in_time, core: in_core, op: in_op, addr: in_addr};

  // Head is eligible only once CPU time has caught up with its arrival stamp
  assign eligible_s = !fifo_empty_s && (head_s.arr_time <= cpu_time_r);
  assign pop_s      = eligible_s && out_ready;

  req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .wr_data   (wr_entry_s),
    .rd_data   (head_s),
    .occupancy (fifo_occ_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Free-running CPU time, wrapping naturally at 2^TIME_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_time_r <= {TIME_W{1'b0}};
    end else begin
      cpu_time_r <= cpu_time_r + TIME_ONE;
    end
  end

  // Arrival-order tracking and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_time_r   <= {TIME_W{1'b0}};
      err_order_r   <= 1'b0;
      err_illegal_r <= 1'b0;
      drop_count_r  <= 8'd0;
    end else begin
      if (push_s) begin
        last_time_r <= in_time;
        if (in_time < last_time_r) begin
          err_order_r <= 1'b1;
        end
      end
      if (drop_s) begin
        err_illegal_r <= 1'b1;
        if (drop_count_r != 8'hFF) begin
          drop_count_r <= drop_count_r + 8'd1;
        end
      end
    end
  end

  // Decode of the head address; fields are meaningless while empty
  always_comb begin
    head_dec_s = decode_addr(head_s.addr[DECODE_W-1:0]);
  end

  assign out_valid   = eligible_s;
  assign out_op      = head_s.op;
  assign out_core    = head_s.core;
  assign out_addr    = head_s.addr;
  assign out_channel = head_dec_s.channel;
  assign out_bg      = head_dec_s.bg;
  assign out_bank    = head_dec_s.bank;
  assign out_row     = head_dec_s.row;
  assign out_col     = head_dec_s.col;
  assign cpu_time    = cpu_time_r;
  assign occupancy   = fifo_occ_s;
  assign full        = fifo_full_s;
  assign empty       = fifo_empty_s;
  assign err_illegal = err_illegal_r;
  assign err_order   = err_order_r;
  assign drop_count  = drop_count_r;

endmodule
